// File: rtl/cnn_rd_pkg.sv
// Shared types and constants for the CNN memory read engine.
// Holds the FSM state enum plus the CNN memory window and image-region geometry.
package cnn_rd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    localparam int WORDS_PER_WIN = 25;
    localparam int WORD_W        = 16;
    localparam int CNN_IMG_BASE  = 50704;
    localparam int CNN_IMG_WORDS = 1024;

endpackage

// File: rtl/cnn_rd_fifo2.sv
// Two-entry FIFO for returned read windows; head is registered, so data appears 1 cycle after push.
// No internal backpressure: the producer's credit accounting keeps it from overflowing; push and pop may share a cycle.
module cnn_rd_fifo2 #(
    parameter int W = 401
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic         o_vld,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_vld     = (r_occ != 2'd0);
    assign o_occ     = r_occ;

endmodule

// File: rtl/cnn_mem_reader.sv
// Walks a base/stride/count address sequence, reads one 25-word window per address and streams it out; start->first out_valid is 3 cycles.
// out_ready stalls throttle reads through a 2-credit return FIFO; CNN_RD_CHECKSUM_EN adds a running 16-bit word sum.
module cnn_mem_reader #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int WORDS  = 25,
    parameter int CNT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [CNT_W-1:0]        count,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [WORDS*WORD_W-1:0] mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_data,
    output logic                    out_last,
    output logic [WORD_W-1:0]       checksum
);

    import cnn_rd_pkg::*;

    localparam int DATA_W = WORDS * WORD_W;

    state_e              r_state;
    state_e              w_next_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_stride;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_delivered;
    logic                r_rd_pending;
    logic                r_rd_last;
    logic                w_start_ok;
    logic                w_issue;
    logic                w_pop;
    logic                w_fifo_vld;
    logic [1:0]          w_occ;
    logic [1:0]          w_credit_used;
    logic [DATA_W:0]     w_head;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_pop      = w_fifo_vld && out_ready;

    // A pop in the same cycle frees its slot before the new read can return, keeping full rate.
    assign w_credit_used = {1'b0, r_rd_pending} + w_occ - {1'b0, w_pop};
    assign w_issue       = (r_state == S_ISSUE) && (r_issued != r_count) && (w_credit_used < 2'd2);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue && ((r_issued + CNT_W'(1)) == r_count)) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_delivered == (r_count - CNT_W'(1)))) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_stride     <= '0;
            r_count      <= '0;
            r_issued     <= '0;
            r_delivered  <= '0;
            r_rd_pending <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_rd_pending <= w_issue;
            r_rd_last    <= w_issue && (r_issued == (r_count - CNT_W'(1)));
            if (w_start_ok) begin
                r_cur_addr  <= base_addr;
                r_stride    <= stride;
                r_count     <= count;
                r_issued    <= '0;
                r_delivered <= '0;
            end else begin
                if (w_issue) begin
                    r_cur_addr <= r_cur_addr + r_stride;
                    r_issued   <= r_issued + CNT_W'(1);
                end
                if (w_pop) begin
                    r_delivered <= r_delivered + CNT_W'(1);
                end
            end
        end
    end

    cnn_rd_fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (r_rd_pending),
        .i_push_dat({r_rd_last, mem_rdata}),
        .i_pop     (w_pop),
        .o_pop_dat (w_head),
        .o_vld     (w_fifo_vld),
        .o_occ     (w_occ)
    );

    assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done      = (r_state == S_FINISH);
    assign mem_rd_en = w_issue;
    assign mem_addr  = r_cur_addr;
    assign out_valid = w_fifo_vld;
    assign out_data  = w_head[DATA_W-1:0];
    assign out_last  = w_fifo_vld && w_head[DATA_W];

`ifdef CNN_RD_CHECKSUM_EN
    logic [WORD_W-1:0] r_checksum;
    logic [WORD_W-1:0] w_win_sum;

    always_comb begin
        w_win_sum = '0;
        for (int k = 0; k < WORDS; k++) begin
            w_win_sum = w_win_sum + w_head[k*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + w_win_sum;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/cnn_mem_reader.md
# cnn_mem_reader

Streaming read engine on the CNN memory's wide read port; the consumer-side counterpart of the load path that fills CNN memory with kernel weights (words 0..50703) and image pixels (words 50704..51727). On a start command it walks a base/stride/count address sequence, reads one 25-word (400-bit) window per address and delivers each window to the convolution datapath over a valid/ready stream. It sits between CNN memory and the conv engine, and is the only reader of that port once `doneLoadingCNN` is high.

## Interface
- `ADDR_W`, 16, CNN memory word-address width.
- `WORD_W`, 16, fixed-point word width.
- `WORDS`, 25, words per window; `DATA_W = WORDS*WORD_W` = 400.
- `CNT_W`, 12, width of the block-count field.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `start`  in  1  command strobe, sampled only in IDLE.
- `base_addr`  in  ADDR_W  first window address.
- `stride`  in  ADDR_W  address increment between windows.
- `count`  in  CNT_W  windows to deliver.
- `busy`  out  1  high from accepted start until the done pulse.
- `done`  out  1  one-cycle pulse after the last window handshakes.
- `mem_rd_en`  out  1  read strobe to CNN memory.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  DATA_W  window data, valid exactly one cycle after `mem_rd_en`.
- `out_valid`  out  1  window available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  DATA_W  window; word k at bits [16k+15:16k].
- `out_last`  out  1  marks the final window of the command.
- `checksum`  out  WORD_W  running word sum (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - `start`=1 latches `base_addr`, `stride` and `count`.
  - count≠0: go to ISSUE.
  - count=0: go straight to FINISH; no reads are issued.
- ISSUE:
  - Issue a read when `outstanding + fifo_occupancy < 2`.
  - Each read drives `mem_addr`=cur_addr, then cur_addr += stride (mod 2^ADDR_W, wrap allowed) and issued += 1.
  - Go to DRAIN when issued == count.
- DRAIN: wait until delivered == count, then go to FINISH.
- FINISH: pulse `done` for one cycle, drop `busy`, return to IDLE.
- Return data is captured into a 2-entry FIFO. The credit rule above guarantees the FIFO never overflows, so no data is ever dropped.
- `out_last` is high with the window whose delivered index equals count−1.
- `start` outside IDLE is ignored; there is no queuing.
- Reset mid-command aborts immediately. No done pulse is generated, and in-flight read data is discarded.

## Timing
- Reset values of all outputs are 0, including `mem_addr`, `out_data` and `checksum`.
- start → first `mem_rd_en`: 1 cycle. First `out_valid`: 3 cycles after start (read latency 1 + FIFO register).
- With `out_ready` held high: one window per cycle, no bubbles after the first.
- `out_valid`/`out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- Same-cycle FIFO push and pop is legal and leaves occupancy unchanged.
- `done` follows the last handshake by 1 cycle. `busy` deasserts on that same cycle.
- `mem_rd_en` never asserts in IDLE or FINISH.

## Configuration
- `CNN_RD_CHECKSUM_EN` defined:
  - `checksum` accumulates the wrapping 16-bit sum of all 25 words of every handshaken window.
  - It clears on an accepted start and holds its value after done.
- Undefined: `checksum` is tied to 0 and no adder is synthesized.

## Structure
- Package `cnn_rd_pkg` holds:
  - the state enum;
  - `WORDS_PER_WIN`=25 and `WORD_W`=16;
  - `CNN_IMG_BASE`=50704 and `CNN_IMG_WORDS`=1024.
- One sub-module, `cnn_rd_fifo2`: a 2-deep DATA_W+1-bit FIFO (data plus last) with push/pop/occupancy outputs.

## Test plan
- **Single window.** base=0, stride=25, count=1, ready=1 → one read at addr 0; `out_valid`+`out_last` at cycle 3; `done` at cycle 4.
- **Full-rate stream.** base=50704, stride=1, count=8, ready=1 → addrs 50704..50711; 8 back-to-back beats; `out_last` on beat 8 only.
- **Backpressure.** count=6, ready toggling 1/0 each cycle → all 6 windows delivered in order with stable data while stalled; `outstanding + occupancy` never exceeds 2.
- **Zero count.** count=0 → no `mem_rd_en`; `done` pulses 1 cycle after start.
- **Address wrap.** base=65530, stride=4, count=3 → addrs 65530, 65534, 2.
- **Abort and checksum.** `rst_n` low during beat 3 of count=10 → all outputs 0 and no done; a new start then runs cleanly. With `CNN_RD_CHECKSUM_EN` defined, all-ones words, count=2 → checksum = 50 × 0xFFFF mod 2^16 = 0xFFCE.
